// File: rtl/ofm_stream_checker.sv
// Purpose : stream the RTL OFM buffer against a golden buffer, LANES words per cycle, and report pass/fail,
//           the mismatch count, and the first failing address with both data values.
// Latency : one group per cycle; start to done = ceil(TOTAL_WORDS/LANES) + RD_LATENCY + 2 cycles on a clean scan.
// Backpressure: none. The read ports must return data exactly RD_LATENCY cycles after rd_en.
//
// Ports: clk, rst (async, active high), start (pulse, honoured only when idle)
//        rd_en / rd_addr     shared read strobe and group base address (lane k reads rd_addr+k)
//        rtl_data/gold_data  LANES packed words, lane k in [k*WORD_WIDTH +: WORD_WIDTH]
//        busy, done (pulse), pass, mismatch_count (saturating), first_err_addr/_rtl/_gold
// Optional: define CMP_TOLERANCE_EN so that a lane matches when |signed(rtl)-signed(gold)| <= TOLERANCE.
//           Without it the compare is exact and TOLERANCE does not affect the logic.
module ofm_stream_checker #(
    parameter int LANES         = 16,
    parameter int WORD_WIDTH    = 16,
    parameter int TOTAL_WORDS   = 346112,
    parameter int ADDR_WIDTH    = 20,
    parameter int RD_LATENCY    = 1,
    parameter int STOP_ON_FIRST = 1,
    parameter int TOLERANCE     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        rd_en,
    output logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [LANES*WORD_WIDTH-1:0] rtl_data,
    input  logic [LANES*WORD_WIDTH-1:0] gold_data,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [ADDR_WIDTH:0]         mismatch_count,
    output logic [ADDR_WIDTH-1:0]       first_err_addr,
    output logic [WORD_WIDTH-1:0]       first_err_rtl,
    output logic [WORD_WIDTH-1:0]       first_err_gold
);

    localparam int EW = ADDR_WIDTH + 2;      // room for rd_addr + LANES without wrapping
    localparam int CW = ADDR_WIDTH + 1;
    localparam int LW = $clog2(LANES + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                state;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic [ADDR_WIDTH-1:0] addr_pipe [RD_LATENCY];
    logic [LANES-1:0]      mask_pipe [RD_LATENCY];

    logic [LANES-1:0]      issue_mask, lane_fail, cmp_mask;
    logic                  last_group, cmp_vld, any_fail, stop_hit, drain_empty;
    logic [LW-1:0]         fail_cnt, first_lane;
    logic [CW:0]           count_sum;
    logic [CW-1:0]         count_next;
    logic [ADDR_WIDTH-1:0] cmp_addr;
    logic [RD_LATENCY-1:0] vld_shifted;
    logic [WORD_WIDTH-1:0] first_rtl_w, first_gold_w;

    function automatic logic lane_bad(input logic [WORD_WIDTH-1:0] a, input logic [WORD_WIDTH-1:0] b);
`ifdef CMP_TOLERANCE_EN
        logic signed [WORD_WIDTH:0] diff;
        logic [WORD_WIDTH:0]        mag;
        // One extra bit keeps the difference of two full-range signed words exact.
        diff = $signed({a[WORD_WIDTH-1], a}) - $signed({b[WORD_WIDTH-1], b});
        mag  = diff[WORD_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        return mag > (WORD_WIDTH+1)'(TOLERANCE);
`else
        return a != b;
`endif
    endfunction

    // Lanes past the end of the buffer in the final group never take part.
    always_comb begin
        issue_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            issue_mask[k] = (EW'(rd_addr) + EW'(k)) < EW'(TOTAL_WORDS);
        end
        last_group = (EW'(rd_addr) + EW'(LANES)) >= EW'(TOTAL_WORDS);
    end

    assign cmp_vld     = vld_pipe[RD_LATENCY-1];
    assign cmp_addr    = addr_pipe[RD_LATENCY-1];
    assign cmp_mask    = mask_pipe[RD_LATENCY-1];
    // Pipeline state after the next edge, ignoring new issues (none happen in DRAIN).
    assign vld_shifted = vld_pipe << 1;
    assign drain_empty = (vld_shifted == '0);

    always_comb begin
        lane_fail  = '0;
        fail_cnt   = '0;
        first_lane = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_fail[k] = cmp_vld && cmp_mask[k]
                        && lane_bad(rtl_data[k*WORD_WIDTH +: WORD_WIDTH], gold_data[k*WORD_WIDTH +: WORD_WIDTH]);
        end
        for (int k = 0; k < LANES; k++) begin
            fail_cnt = fail_cnt + LW'(lane_fail[k]);
        end
        // Scan downward so the lowest failing lane wins.
        for (int k = LANES - 1; k >= 0; k--) begin
            if (lane_fail[k]) first_lane = LW'(k);
        end
        any_fail   = |lane_fail;
        stop_hit   = (STOP_ON_FIRST != 0) && any_fail;
        count_sum  = {1'b0, mismatch_count} + (CW+1)'(fail_cnt);
        count_next = count_sum[CW] ? '1 : count_sum[CW-1:0];
    end

    assign first_rtl_w  = rtl_data[first_lane*WORD_WIDTH +: WORD_WIDTH];
    assign first_gold_w = gold_data[first_lane*WORD_WIDTH +: WORD_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rd_en          <= 1'b0;
            rd_addr        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_err_addr <= '0;
            first_err_rtl  <= '0;
            first_err_gold <= '0;
            vld_pipe       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                addr_pipe[i] <= '0;
                mask_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= rd_en;
            addr_pipe[0] <= rd_addr;
            mask_pipe[0] <= issue_mask;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
                mask_pipe[i] <= mask_pipe[i-1];
            end
            done <= 1'b0;

            if (cmp_vld) begin
                mismatch_count <= count_next;
                // A zero count means no error has been captured yet in this check.
                if (any_fail && (mismatch_count == '0)) begin
                    first_err_addr <= cmp_addr + ADDR_WIDTH'(first_lane);
                    first_err_rtl  <= first_rtl_w;
                    first_err_gold <= first_gold_w;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        pass           <= 1'b0;
                        mismatch_count <= '0;
                        first_err_addr <= '0;
                        first_err_rtl  <= '0;
                        first_err_gold <= '0;
                        rd_addr        <= '0;
                        rd_en          <= 1'b1;
                        busy           <= 1'b1;
                        state          <= READ;
                    end
                end
                READ: begin
                    if (stop_hit) begin
                        // Groups still in flight are dropped: neither compared nor counted.
                        rd_en    <= 1'b0;
                        vld_pipe <= '0;
                        state    <= DRAIN;
                    end else if (last_group) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_addr <= rd_addr + ADDR_WIDTH'(LANES);
                    end
                end
                DRAIN: begin
                    if (stop_hit) vld_pipe <= '0;
                    if (stop_hit || drain_empty) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= (mismatch_count == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Configuration guard: latency range, non-negative tolerance, address space covers the buffer.
    cfg_ok: assert property (@(posedge clk) disable iff (rst)
        (RD_LATENCY >= 1) && (RD_LATENCY <= 4) && (TOLERANCE >= 0)
        && ((64'd1 << ADDR_WIDTH) >= 64'(TOTAL_WORDS)));

endmodule
